// File: rtl/legv8_arb_pkg.sv
// Shared types and constants for the LEGv8 unified-memory arbiter.
package legv8_arb_pkg;

  localparam int unsigned LatCntW = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GntIf = 1'b0,
    GntD  = 1'b1
  } arb_gnt_e;

  // Instruction words are 32 bits packed two per memory doubleword.
  function automatic logic [31:0] fetch_word(input logic [63:0] dw, input logic hi);
    return hi ? dw[63:32] : dw[31:0];
  endfunction

endpackage

// File: rtl/legv8_mem_arbiter_if.sv
// Fetch/data requester handshakes plus the single-port memory bus of the arbiter.
interface legv8_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [63:0]       d_wdata;
  logic              d_ack;
  logic [63:0]       d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-4:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/legv8_starve_counter.sv
// Saturating count of arbitrations fetch has lost in a row.
module legv8_starve_counter #(
  parameter int unsigned Limit = 4,
  parameter int unsigned Width = 4
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  logic [Width-1:0] cnt_q;

  assign at_limit_o = (cnt_q == Width'(Limit));

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && !at_limit_o) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

endmodule

// File: rtl/legv8_mem_arbiter.sv
// Data-priority arbiter for one unified memory shared by LEGv8 fetch and LDUR/STUR.
// Optional grant statistics are compiled in with LEGV8_ARB_STATS_EN.
module legv8_mem_arbiter
  import legv8_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clock,
  input  logic               reset,
  legv8_mem_arbiter_if.slave bus
`ifdef LEGV8_ARB_STATS_EN
  ,
  output logic [31:0]        stat_if_grants,
  output logic [31:0]        stat_d_grants,
  output logic [15:0]        stat_starve_overrides
`endif
);

  arb_state_e          state_q;
  arb_gnt_e            gnt_q;
  logic [LatCntW-1:0]  lat_q;
  logic                hi_q;
  logic                mem_en_q, mem_we_q, if_ack_q, d_ack_q;
  logic [ADDR_W-4:0]   mem_addr_q;
  logic [63:0]         mem_wdata_q, d_rdata_q;
  logic [31:0]         if_rdata_q;
  logic                at_limit, any_req, fetch_win, issue_go, starve_inc, starve_clr;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{bus.if_addr[1:0], bus.d_addr[2:0]};

  assign any_req    = bus.if_req | bus.d_req;
  assign fetch_win  = bus.if_req & (~bus.d_req | at_limit);
  assign issue_go   = (state_q == StIdle) & any_req;
  assign starve_inc = (state_q == StIdle) & bus.d_req & bus.if_req & ~at_limit;
  assign starve_clr = (state_q == StIdle) & (~bus.if_req | fetch_win);

  legv8_starve_counter #(
    .Limit (STARVE_LIMIT),
    .Width (LatCntW)
  ) u_starve (
    .clock_i    (clock),
    .reset_i    (reset),
    .inc_i      (starve_inc),
    .clr_i      (starve_clr),
    .at_limit_o (at_limit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      gnt_q       <= GntIf;
      lat_q       <= '0;
      hi_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      mem_en_q <= 1'b0;
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (issue_go) begin
            state_q     <= StIssue;
            mem_en_q    <= 1'b1;
            mem_wdata_q <= bus.d_wdata;
            if (fetch_win) begin
              gnt_q      <= GntIf;
              mem_we_q   <= 1'b0;
              mem_addr_q <= bus.if_addr[ADDR_W-1:3];
              hi_q       <= bus.if_addr[2];
            end else begin
              gnt_q      <= GntD;
              mem_we_q   <= bus.d_we;
              mem_addr_q <= bus.d_addr[ADDR_W-1:3];
            end
          end
        end
        StIssue: begin
          lat_q   <= LatCntW'(MEM_LATENCY);
          state_q <= StWait;
        end
        StWait: begin
          // lat_q == 1 marks the cycle mem_rdata is valid.
          if (lat_q == LatCntW'(1)) begin
            state_q <= StResp;
            if (gnt_q == GntIf) begin
              if_rdata_q <= fetch_word(bus.mem_rdata, hi_q);
              if_ack_q   <= 1'b1;
            end else begin
              if (!mem_we_q) d_rdata_q <= bus.mem_rdata;
              d_ack_q <= 1'b1;
            end
          end else begin
            lat_q <= lat_q - LatCntW'(1);
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;

`ifdef LEGV8_ARB_STATS_EN
  logic [31:0] if_grants_q, d_grants_q;
  logic [15:0] overrides_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      if_grants_q <= '0;
      d_grants_q  <= '0;
      overrides_q <= '0;
    end else if (issue_go) begin
      if (fetch_win) begin
        if (if_grants_q != '1) if_grants_q <= if_grants_q + 32'd1;
        if (bus.d_req && overrides_q != '1) overrides_q <= overrides_q + 16'd1;
      end else if (d_grants_q != '1) begin
        d_grants_q <= d_grants_q + 32'd1;
      end
    end
  end

  assign stat_if_grants        = if_grants_q;
  assign stat_d_grants         = d_grants_q;
  assign stat_starve_overrides = overrides_q;
`endif

endmodule

// File: tb/tb_legv8_mem_arbiter.sv
// Directed bench: dut1 has MEM_LATENCY=1/STARVE_LIMIT=2, dut3 has MEM_LATENCY=3/STARVE_LIMIT=4.
module tb_legv8_mem_arbiter;

  localparam logic [63:0] C1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] C2 = 64'hFEED_FACE_0BAD_F00D;
  localparam logic [63:0] J3 = 64'h5A5A_5A5A_A5A5_A5A5;
  localparam logic [63:0] V3 = 64'hCAFE_BABE_DEAD_BEEF;
  localparam logic [63:0] V4 = 64'h7777_8888_9999_AAAA;
  localparam logic [63:0] V5 = 64'h0F0F_1E1E_2D2D_3C3C;
  localparam logic [5:0]  EXP_ORDER = 6'b011011;  // bit i = 1 means data granted i-th

  logic clock, rst1, rst3;
  int   checks, failures;

  legv8_mem_arbiter_if #(.ADDR_W(64)) b1 ();
  legv8_mem_arbiter_if #(.ADDR_W(64)) b3 ();

`ifdef LEGV8_ARB_STATS_EN
  logic [31:0] s1_if, s1_d, s3_if, s3_d;
  logic [15:0] s1_ov, s3_ov;
`endif

  legv8_mem_arbiter #(.ADDR_W(64), .MEM_LATENCY(1), .STARVE_LIMIT(2)) dut1 (
    .clock (clock),
    .reset (rst1),
    .bus   (b1)
`ifdef LEGV8_ARB_STATS_EN
    , .stat_if_grants(s1_if), .stat_d_grants(s1_d), .stat_starve_overrides(s1_ov)
`endif
  );

  legv8_mem_arbiter #(.ADDR_W(64), .MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .clock (clock),
    .reset (rst3),
    .bus   (b3)
`ifdef LEGV8_ARB_STATS_EN
    , .stat_if_grants(s3_if), .stat_d_grants(s3_d), .stat_starve_overrides(s3_ov)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst3 = 1'b1;
    tick(); tick();
    checks += 8;
    if (b1.if_ack !== 1'b0) begin failures++; $display("FAIL rst_if_ack: got %b want 0", b1.if_ack); end
    if (b1.d_ack !== 1'b0) begin failures++; $display("FAIL rst_d_ack: got %b want 0", b1.d_ack); end
    if (b1.mem_en !== 1'b0) begin failures++; $display("FAIL rst_mem_en: got %b want 0", b1.mem_en); end
    if (b1.mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we: got %b want 0", b1.mem_we); end
    if (b1.mem_addr !== 61'h0) begin failures++; $display("FAIL rst_mem_addr: got %h want 0", b1.mem_addr); end
    if (b1.if_rdata !== 32'h0) begin failures++; $display("FAIL rst_if_rdata: got %h want 0", b1.if_rdata); end
    if (b1.d_rdata !== 64'h0) begin failures++; $display("FAIL rst_d_rdata: got %h want 0", b1.d_rdata); end
    if (b3.mem_en !== 1'b0) begin failures++; $display("FAIL rst3_mem_en: got %b want 0", b3.mem_en); end
`ifdef LEGV8_ARB_STATS_EN
    checks++;
    if ({s1_if, s1_d, s1_ov} !== 80'h0) begin
      failures++; $display("FAIL rst_stats: got %h want 0", {s1_if, s1_d, s1_ov});
    end
`endif
    rst1 = 1'b0; rst3 = 1'b0;
  endtask

  task automatic test_fetch();
    b1.if_req = 1'b1; b1.if_addr = 64'h1004;
    tick();
    checks += 3;
    if (b1.mem_en !== 1'b1) begin failures++; $display("FAIL fetch_mem_en: got %b want 1", b1.mem_en); end
    if (b1.mem_addr !== 61'h200) begin failures++; $display("FAIL fetch_mem_addr: got %h want 200", b1.mem_addr); end
    if (b1.mem_we !== 1'b0) begin failures++; $display("FAIL fetch_mem_we: got %b want 0", b1.mem_we); end
    tick();
    b1.mem_rdata = 64'hAAAAAAAA_55555555;
    checks += 2;
    if (b1.mem_en !== 1'b0) begin failures++; $display("FAIL fetch_en_pulse: got %b want 0", b1.mem_en); end
    if (b1.if_ack !== 1'b0) begin failures++; $display("FAIL fetch_early_ack: got %b want 0", b1.if_ack); end
    tick();
    b1.mem_rdata = C1;
    checks += 3;
    if (b1.if_ack !== 1'b1) begin failures++; $display("FAIL fetch_ack: got %b want 1", b1.if_ack); end
    if (b1.if_rdata !== 32'hAAAAAAAA) begin failures++; $display("FAIL fetch_rdata: got %h want aaaaaaaa", b1.if_rdata); end
    if (b1.d_ack !== 1'b0) begin failures++; $display("FAIL fetch_d_ack: got %b want 0", b1.d_ack); end
    b1.if_req = 1'b0;
    tick();
    checks++;
    if (b1.if_ack !== 1'b0) begin failures++; $display("FAIL fetch_ack_width: got %b want 0", b1.if_ack); end
  endtask

  task automatic test_simultaneous();
    int d_cyc, i_cyc;
    logic both;
    d_cyc = -1; i_cyc = -1; both = 1'b0;
    b1.if_req = 1'b1; b1.if_addr = 64'h2000;
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 64'h40;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (b1.d_ack && b1.if_ack) both = 1'b1;
      if (b1.d_ack) begin
        d_cyc = c; b1.d_req = 1'b0;
        checks++;
        if (b1.d_rdata !== C1) begin failures++; $display("FAIL simul_d_rdata: got %h want %h", b1.d_rdata, C1); end
      end
      if (b1.if_ack) begin
        i_cyc = c; b1.if_req = 1'b0;
        checks++;
        if (b1.if_rdata !== C1[31:0]) begin failures++; $display("FAIL simul_if_rdata: got %h want %h", b1.if_rdata, C1[31:0]); end
      end
    end
    checks += 3;
    if (d_cyc != 3) begin failures++; $display("FAIL simul_d_ack_cycle: got %0d want 3", d_cyc); end
    if (i_cyc != 7) begin failures++; $display("FAIL simul_if_ack_cycle: got %0d want 7", i_cyc); end
    if (both !== 1'b0) begin failures++; $display("FAIL simul_dual_ack: got %b want 0", both); end
  endtask

  task automatic test_starvation();
    logic [5:0] order;
    int n;
    logic both;
    order = '0; n = 0; both = 1'b0;
    b1.if_req = 1'b1; b1.if_addr = 64'h3000;
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 64'h50;
    for (int c = 0; c < 40 && n < 6; c++) begin
      tick();
      if (b1.d_ack && b1.if_ack) both = 1'b1;
      if (b1.d_ack || b1.if_ack) begin
        order[n] = b1.d_ack;
        n++;
      end
    end
    b1.if_req = 1'b0; b1.d_req = 1'b0;
    tick();
    checks += 2;
    if (n != 6) begin failures++; $display("FAIL starve_ack_count: got %0d want 6", n); end
    if (both !== 1'b0) begin failures++; $display("FAIL starve_dual_ack: got %b want 0", both); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (order[i] !== EXP_ORDER[i]) begin
        failures++; $display("FAIL starve_grant_%0d: got %s want %s", i,
                             order[i] ? "D" : "IF", EXP_ORDER[i] ? "D" : "IF");
      end
    end
  endtask

  task automatic test_store();
    b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 64'h18; b1.d_wdata = 64'h0123456789ABCDEF;
    tick();
    checks += 4;
    if (b1.mem_en !== 1'b1) begin failures++; $display("FAIL store_mem_en: got %b want 1", b1.mem_en); end
    if (b1.mem_we !== 1'b1) begin failures++; $display("FAIL store_mem_we: got %b want 1", b1.mem_we); end
    if (b1.mem_addr !== 61'h3) begin failures++; $display("FAIL store_mem_addr: got %h want 3", b1.mem_addr); end
    if (b1.mem_wdata !== 64'h0123456789ABCDEF) begin
      failures++; $display("FAIL store_mem_wdata: got %h want 0123456789abcdef", b1.mem_wdata);
    end
    tick();
    b1.mem_rdata = C2;
    tick();
    b1.mem_rdata = C1;
    checks += 2;
    if (b1.d_ack !== 1'b1) begin failures++; $display("FAIL store_ack: got %b want 1", b1.d_ack); end
    if (b1.d_rdata !== C1) begin failures++; $display("FAIL store_d_rdata: got %h want %h", b1.d_rdata, C1); end
    b1.d_req = 1'b0; b1.d_we = 1'b0;
    tick();
    checks++;
    if (b1.d_ack !== 1'b0) begin failures++; $display("FAIL store_ack_width: got %b want 0", b1.d_ack); end
  endtask

  task automatic test_latency3();
    b3.d_req = 1'b1; b3.d_we = 1'b0; b3.d_addr = 64'h100;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) begin
        checks += 2;
        if (b3.mem_en !== 1'b1) begin failures++; $display("FAIL lat3_mem_en: got %b want 1", b3.mem_en); end
        if (b3.mem_addr !== 61'h20) begin failures++; $display("FAIL lat3_mem_addr: got %h want 20", b3.mem_addr); end
      end
      if (c >= 2 && c <= 4) begin
        checks++;
        if (b3.d_ack !== 1'b0) begin failures++; $display("FAIL lat3_early_ack_c%0d: got %b want 0", c, b3.d_ack); end
      end
      if (c == 4) b3.mem_rdata = V3;
      if (c == 5) begin
        b3.mem_rdata = J3;
        checks += 2;
        if (b3.d_ack !== 1'b1) begin failures++; $display("FAIL lat3_ack: got %b want 1", b3.d_ack); end
        if (b3.d_rdata !== V3) begin failures++; $display("FAIL lat3_d_rdata: got %h want %h", b3.d_rdata, V3); end
      end
    end
    b3.d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    b3.d_req = 1'b1; b3.d_we = 1'b0; b3.d_addr = 64'h200;
    tick();  // T+1 issue
    tick();  // T+2 wait
    rst3 = 1'b1; b3.d_req = 1'b0;
    tick();  // T+3
    rst3 = 1'b0;
    checks += 4;
    if (b3.d_ack !== 1'b0) begin failures++; $display("FAIL midrst_d_ack: got %b want 0", b3.d_ack); end
    if (b3.if_ack !== 1'b0) begin failures++; $display("FAIL midrst_if_ack: got %b want 0", b3.if_ack); end
    if (b3.mem_en !== 1'b0) begin failures++; $display("FAIL midrst_mem_en: got %b want 0", b3.mem_en); end
    if (b3.d_rdata !== 64'h0) begin failures++; $display("FAIL midrst_d_rdata: got %h want 0", b3.d_rdata); end
`ifdef LEGV8_ARB_STATS_EN
    checks++;
    if ({s3_if, s3_d, s3_ov} !== 80'h0) begin
      failures++; $display("FAIL midrst_stats: got %h want 0", {s3_if, s3_d, s3_ov});
    end
`endif
    // A fresh request must issue immediately, proving the arbiter is back in idle.
    b3.d_req = 1'b1; b3.d_addr = 64'h08;
    tick();  // T+4: stale data would be valid here
    b3.mem_rdata = V4;
    checks += 2;
    if (b3.mem_en !== 1'b1) begin failures++; $display("FAIL midrst_reissue_en: got %b want 1", b3.mem_en); end
    if (b3.mem_addr !== 61'h1) begin failures++; $display("FAIL midrst_reissue_addr: got %h want 1", b3.mem_addr); end
    tick();  // T+5
    b3.mem_rdata = J3;
    checks += 2;
    if (b3.d_rdata !== 64'h0) begin failures++; $display("FAIL midrst_stale_capture: got %h want 0", b3.d_rdata); end
    if (b3.d_ack !== 1'b0) begin failures++; $display("FAIL midrst_stale_ack: got %b want 0", b3.d_ack); end
    tick();  // T+6
    tick();  // T+7
    b3.mem_rdata = V5;
    tick();  // T+8
    b3.mem_rdata = J3;
    checks += 2;
    if (b3.d_ack !== 1'b1) begin failures++; $display("FAIL midrst_reissue_ack: got %b want 1", b3.d_ack); end
    if (b3.d_rdata !== V5) begin failures++; $display("FAIL midrst_reissue_rdata: got %h want %h", b3.d_rdata, V5); end
    b3.d_req = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst1 = 1'b1; rst3 = 1'b1;
    b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0;
    b1.d_addr = '0; b1.d_wdata = '0; b1.mem_rdata = C1;
    b3.if_req = 1'b0; b3.if_addr = '0; b3.d_req = 1'b0; b3.d_we = 1'b0;
    b3.d_addr = '0; b3.d_wdata = '0; b3.mem_rdata = J3;
    test_reset();
    test_fetch();
    test_simultaneous();
    test_starvation();
    test_store();
    test_latency3();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
